bcd_seg_mux: RTL and testbench
==============================

# bcd_seg_mux

Time-multiplexed two-digit seven-segment driver that sits directly downstream of the binary-to-BCD converter. It consumes the tens/ones BCD digits, captures them on a load strobe, and scans them onto a shared segment bus with per-digit anode enables. A blanking gap between digits prevents ghosting. Non-decimal codes are shown as a dash.

## Interface
Parameters:
- REFRESH_DIV, default 50000: clock cycles each digit is lit (≥1).
- BLANK_CYC, default 500: clock cycles all anodes are off between digits (≥1).

Ports:
- i_Clk  in  1  clock; all state changes on its rising edge.
- i_Rst  in  1  asynchronous, active-high reset.
- i_Load  in  1  capture strobe; samples i_Tens/i_Ones on any edge where it is high.
- i_Tens  in  4  BCD tens digit from the converter.
- i_Ones  in  4  BCD ones digit from the converter.
- o_Seg  out  7  segments, active-low, bit order {g,f,e,d,c,b,a}.
- o_An  out  2  digit enables, active-low; [0] is the ones digit, [1] is the tens digit.
- o_Frame  out  1  one-cycle pulse on entry to ONES (start of scan frame).

## Operation
- Capture register {cap_tens, cap_ones} resets to 0. It loads on an edge with i_Load=1. There is no handshake back to the source.
- FSM states are ONES → BLANK_A → TENS → BLANK_B → ONES. Each state holds for its dwell: REFRESH_DIV cycles in ONES/TENS, BLANK_CYC cycles in the BLANK states.
- Dwell counter resets to 0 on every state entry. The FSM advances on the edge where counter = dwell−1.
- Display digit is frozen at state entry from the capture register. Its value counts as of that same edge, so a load on the entry edge is not shown until the next entry of that digit.
- A load mid-digit never changes the lit segments until the next entry.
- Decode: 0–9 → standard glyphs (0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10). Codes 10–15 → dash 7'h3F.
- Output values by state:
  - ONES: o_An=2'b10, o_Seg=decode(ones).
  - TENS: o_An=2'b01, o_Seg=decode(tens).
  - BLANK states: o_An=2'b11, o_Seg=7'h7F.

## Timing
- All outputs are registered and update on the same edge as the state register. There is no combinational input→output path.
- Reset values: state=BLANK_B, counter=0, o_Seg=7'h7F, o_An=2'b11, o_Frame=0.
- First ONES entry occurs BLANK_CYC edges after reset deassertion.
- Frame period is 2·(REFRESH_DIV+BLANK_CYC) cycles.
- Load-to-display latency is at most one frame period.
- Reset asserted mid-digit blanks the outputs immediately (asynchronously) and clears captured digits to 0.
- o_An never has both bits low in any cycle, including across transitions and reset.

## Configuration
- LEAD_ZERO_BLANK_EN defined: when the frozen tens digit is 0, TENS drives o_An=2'b11 and o_Seg=7'h7F. State and dwell timing are unchanged.
- LEAD_ZERO_BLANK_EN undefined: a tens value of 0 displays glyph 7'h40.

## Structure
- Shared package seg_pkg holds:
  - the state enum (ONES, BLANK_A, TENS, BLANK_B);
  - SEG_OFF=7'h7F and SEG_DASH=7'h3F;
  - the glyph constants.
- One sub-module, bcd_to_seg7: purely combinational 4-bit → 7-bit decoder, instanced once on the mux output before the output register.

## Test plan
Bench parameters are REFRESH_DIV=4 and BLANK_CYC=1, giving a frame of 10 cycles.
- **Reset:** assert i_Rst mid-run.
  - Outputs go immediately to o_An=11, o_Seg=7F.
  - After release: 1 blank cycle, then ONES with o_Seg=7'h40 and o_Frame pulse.
- **Load tens=4, ones=2:**
  - ONES shows o_An=10, o_Seg=7'h24 for 4 cycles.
  - Then blank for 1 cycle.
  - Then TENS shows o_An=01, o_Seg=7'h19 for 4 cycles.
- **Mid-digit load:** load ones=7 during cycle 2 of ONES.
  - o_Seg stays at the old glyph until the next ONES entry, then shows 7'h78.
- **Invalid code:** load tens=4'hC, ones=4'hF.
  - Both digits show 7'h3F.
- **Leading zero:** load tens=0, ones=5.
  - With LEAD_ZERO_BLANK_EN: TENS shows o_An=11, o_Seg=7F.
  - Without it: TENS shows o_An=01, o_Seg=7'h40.
  - ONES shows 7'h12 in both builds.
- **Random run, 10k cycles:**
  - o_An never equals 2'b00.
  - o_Frame pulses exactly every 10 cycles.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and glyph constants for the two-digit seven-segment scanner.
// Segments are active-low, bit order {g,f,e,d,c,b,a}.
package seg_pkg;

   typedef enum logic [1:0] {
      ONES,
      BLANK_A,
      TENS,
      BLANK_B
   } state_t;

   localparam logic [6:0] SEG_OFF  = 7'h7F;
   localparam logic [6:0] SEG_DASH = 7'h3F;

   localparam logic [6:0] GLYPH_0 = 7'h40;
   localparam logic [6:0] GLYPH_1 = 7'h79;
   localparam logic [6:0] GLYPH_2 = 7'h24;
   localparam logic [6:0] GLYPH_3 = 7'h30;
   localparam logic [6:0] GLYPH_4 = 7'h19;
   localparam logic [6:0] GLYPH_5 = 7'h12;
   localparam logic [6:0] GLYPH_6 = 7'h02;
   localparam logic [6:0] GLYPH_7 = 7'h78;
   localparam logic [6:0] GLYPH_8 = 7'h00;
   localparam logic [6:0] GLYPH_9 = 7'h10;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low seven-segment decoder.
// Codes 10-15 decode to a dash.
module bcd_to_seg7
   import seg_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (bcd)
         4'd0:    seg = GLYPH_0;
         4'd1:    seg = GLYPH_1;
         4'd2:    seg = GLYPH_2;
         4'd3:    seg = GLYPH_3;
         4'd4:    seg = GLYPH_4;
         4'd5:    seg = GLYPH_5;
         4'd6:    seg = GLYPH_6;
         4'd7:    seg = GLYPH_7;
         4'd8:    seg = GLYPH_8;
         4'd9:    seg = GLYPH_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/bcd_seg_mux.sv
// Two-digit time-multiplexed seven-segment driver with blanking gaps.
// Define LEAD_ZERO_BLANK_EN to blank the tens digit when it is zero.
module bcd_seg_mux
   import seg_pkg::*;
#(
   parameter int REFRESH_DIV = 50000,
   parameter int BLANK_CYC   = 500
)(
   input  logic       i_Clk,
   input  logic       i_Rst,
   input  logic       i_Load,
   input  logic [3:0] i_Tens,
   input  logic [3:0] i_Ones,
   output logic [6:0] o_Seg,
   output logic [1:0] o_An,
   output logic       o_Frame
);

   localparam int MAXD = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
   localparam int CW   = $clog2(MAXD + 1);
   localparam logic [CW-1:0] LAST_LIT = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] LAST_BLK = CW'(BLANK_CYC - 1);

   state_t        state;
   state_t        nxt;
   logic [CW-1:0] cnt;
   logic [3:0]    cap_tens;
   logic [3:0]    cap_ones;
   logic [3:0]    digit;
   logic [6:0]    glyph;
   logic          last;

   always_comb begin
      last = (cnt == (((state == ONES) || (state == TENS)) ? LAST_LIT : LAST_BLK));
      case (state)
         ONES:    nxt = BLANK_A;
         BLANK_A: nxt = TENS;
         TENS:    nxt = BLANK_B;
         default: nxt = ONES;
      endcase
      digit = (nxt == TENS) ? cap_tens : cap_ones;
   end

   bcd_to_seg7 u_dec (
      .bcd (digit),
      .seg (glyph)
   );

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         cap_tens <= 4'd0;
         cap_ones <= 4'd0;
      end else if (i_Load) begin
         cap_tens <= i_Tens;
         cap_ones <= i_Ones;
      end
   end

   // Outputs are loaded only on state entry, freezing the lit digit for the dwell.
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         state   <= BLANK_B;
         cnt     <= '0;
         o_Seg   <= SEG_OFF;
         o_An    <= 2'b11;
         o_Frame <= 1'b0;
      end else begin
         o_Frame <= 1'b0;
         if (last) begin
            state <= nxt;
            cnt   <= '0;
            case (nxt)
               ONES: begin
                  o_An    <= 2'b10;
                  o_Seg   <= glyph;
                  o_Frame <= 1'b1;
               end
               TENS: begin
`ifdef LEAD_ZERO_BLANK_EN
                  if (cap_tens == 4'd0) begin
                     o_An  <= 2'b11;
                     o_Seg <= SEG_OFF;
                  end else begin
                     o_An  <= 2'b01;
                     o_Seg <= glyph;
                  end
`else
                  o_An  <= 2'b01;
                  o_Seg <= glyph;
`endif
               end
               default: begin
                  o_An  <= 2'b11;
                  o_Seg <= SEG_OFF;
               end
            endcase
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_bcd_seg_mux.sv
// Directed plus randomized check of bcd_seg_mux with REFRESH_DIV=4, BLANK_CYC=1.
// Expected glyphs come from a hand-written table; frame period is 10 cycles.
module tb_bcd_seg_mux;

   logic       i_Clk;
   logic       i_Rst;
   logic       i_Load;
   logic [3:0] i_Tens;
   logic [3:0] i_Ones;
   logic [6:0] o_Seg;
   logic [1:0] o_An;
   logic       o_Frame;

   int vectors;
   int miscompares;

   bcd_seg_mux #(
      .REFRESH_DIV (4),
      .BLANK_CYC   (1)
   ) dut (
      .i_Clk   (i_Clk),
      .i_Rst   (i_Rst),
      .i_Load  (i_Load),
      .i_Tens  (i_Tens),
      .i_Ones  (i_Ones),
      .o_Seg   (o_Seg),
      .o_An    (o_An),
      .o_Frame (o_Frame)
   );

   initial i_Clk = 1'b0;
   always #5 i_Clk = ~i_Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge i_Clk);
      #1;
      check("an_not_00", 32'(o_An == 2'b00), 32'd0);
   endtask

   task automatic load(input logic [3:0] t, input logic [3:0] o);
      i_Load = 1'b1;
      i_Tens = t;
      i_Ones = o;
   endtask

   function automatic logic [6:0] glyph(input logic [3:0] d);
      case (d)
         4'd0:    return 7'h40;
         4'd1:    return 7'h79;
         4'd2:    return 7'h24;
         4'd3:    return 7'h30;
         4'd4:    return 7'h19;
         4'd5:    return 7'h12;
         4'd6:    return 7'h02;
         4'd7:    return 7'h78;
         4'd8:    return 7'h00;
         4'd9:    return 7'h10;
         default: return 7'h3F;
      endcase
   endfunction

   function automatic logic [8:0] tens_exp(input logic [3:0] d);
`ifdef LEAD_ZERO_BLANK_EN
      if (d == 4'd0) return {2'b11, 7'h7F};
`endif
      return {2'b01, glyph(d)};
   endfunction

   logic [3:0] m_tens;
   logic [3:0] m_ones;
   logic [3:0] p_tens;
   logic [3:0] p_ones;
   logic       pend;
   int         since;

   initial begin
      vectors     = 0;
      miscompares = 0;
      i_Rst  = 1'b1;
      i_Load = 1'b0;
      i_Tens = 4'd0;
      i_Ones = 4'd0;
      #1;
      check("rst_an", 32'(o_An), 32'h3);
      check("rst_seg", 32'(o_Seg), 32'h7F);
      check("rst_frame", 32'(o_Frame), 32'h0);
      #21 i_Rst = 1'b0;

      // first ONES entry one edge after release
      step();
      check("boot_frame", 32'(o_Frame), 32'h1);
      check("boot_seg", 32'(o_Seg), 32'h40);
      load(4'd9, 4'd9);
      step();
      i_Load = 1'b0;
      repeat (9) step();
      check("nines_frame", 32'(o_Frame), 32'h1);
      check("nines_an", 32'(o_An), 32'h2);
      check("nines_seg", 32'(o_Seg), 32'h10);

      // asynchronous reset mid-digit
      step();
      #2 i_Rst = 1'b1;
      #1;
      check("async_rst_an", 32'(o_An), 32'h3);
      check("async_rst_seg", 32'(o_Seg), 32'h7F);
      @(negedge i_Clk);
      check("rst_hold_an", 32'(o_An), 32'h3);
      i_Rst = 1'b0;
      step();
      check("post_rst_frame", 32'(o_Frame), 32'h1);
      check("post_rst_an", 32'(o_An), 32'h2);
      check("post_rst_seg", 32'(o_Seg), 32'h40);

      // tens=4 ones=2
      load(4'd4, 4'd2);
      step();
      i_Load = 1'b0;
      repeat (8) step();
      for (int i = 0; i < 4; i++) begin
         step();
         check("l42_frame", 32'(o_Frame), 32'(i == 0));
         check("l42_ones", {o_An, o_Seg}, {2'b10, 7'h24});
      end
      step();
      check("l42_blank", {o_An, o_Seg}, {2'b11, 7'h7F});
      for (int i = 0; i < 4; i++) begin
         step();
         check("l42_tens", {o_An, o_Seg}, {2'b01, 7'h19});
      end
      step();
      check("l42_blank_b", {o_An, o_Seg}, {2'b11, 7'h7F});

      // load mid-digit
      step();
      check("mid_entry", 32'(o_Seg), 32'h24);
      step();
      load(4'd4, 4'd7);
      step();
      i_Load = 1'b0;
      check("mid_hold0", 32'(o_Seg), 32'h24);
      step();
      check("mid_hold1", 32'(o_Seg), 32'h24);
      repeat (6) step();
      step();
      check("mid_next", {o_An, o_Seg}, {2'b10, 7'h78});

      // invalid codes
      load(4'hC, 4'hF);
      step();
      i_Load = 1'b0;
      repeat (8) step();
      step();
      check("bad_ones", {o_An, o_Seg}, {2'b10, 7'h3F});
      repeat (4) step();
      step();
      check("bad_tens", {o_An, o_Seg}, {2'b01, 7'h3F});

      // leading zero
      load(4'd0, 4'd5);
      step();
      i_Load = 1'b0;
      repeat (3) step();
      step();
      check("lz_ones", {o_An, o_Seg}, {2'b10, 7'h12});
      repeat (4) step();
      step();
`ifdef LEAD_ZERO_BLANK_EN
      check("lz_tens", {o_An, o_Seg}, {2'b11, 7'h7F});
`else
      check("lz_tens", {o_An, o_Seg}, {2'b01, 7'h40});
`endif

      // random loads with a reference capture model
      m_tens = 4'd0;
      m_ones = 4'd5;
      pend   = 1'b0;
      p_tens = 4'd0;
      p_ones = 4'd0;
      since  = 5;
      for (int i = 0; i < 10000; i++) begin
         step();
         since++;
         if (o_Frame) begin
            check("frame_period", 32'(since), 32'd10);
            check("rand_ones", {o_An, o_Seg}, {2'b10, glyph(m_ones)});
            since = 0;
         end else if (since > 10) begin
            check("frame_missing", 32'(since), 32'd10);
            since = 0;
         end
         if (since == 5)
            check("rand_tens", {o_An, o_Seg}, tens_exp(m_tens));
         if (pend) begin
            m_tens = p_tens;
            m_ones = p_ones;
         end
         i_Load = ($urandom_range(0, 3) == 0);
         i_Tens = 4'($urandom);
         i_Ones = 4'($urandom);
         pend   = i_Load;
         p_tens = i_Tens;
         p_ones = i_Ones;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
